// File: rtl/core_mem_arbiter_if.sv
// Request/completion bus shared by fetch, the LSU and the memory port.
// The arbiter takes the master view; the requesters and memory side take the slave view.
interface core_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32   // must stay 32: the strobe field is 4 bits wide
);
    // Instruction fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic              if_err;
    logic [DATA_W-1:0] if_rdata;

    // Load/store requester
    logic              ls_req;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_we;
    logic [3:0]        ls_wstrb;
    logic              ls_ack;
    logic              ls_err;
    logic [DATA_W-1:0] ls_rdata;

    // Memory interconnect port
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [3:0]        mem_wstrb;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr,
        output if_ack, if_err, if_rdata,
        input  ls_req, ls_addr, ls_wdata, ls_we, ls_wstrb,
        output ls_ack, ls_err, ls_rdata,
        output mem_req, mem_addr, mem_wdata, mem_we, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_ack, if_err, if_rdata,
        output ls_req, ls_addr, ls_wdata, ls_we, ls_wstrb,
        input  ls_ack, ls_err, ls_rdata,
        input  mem_req, mem_addr, mem_wdata, mem_we, mem_wstrb,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// the load/store unit, with a watchdog that aborts unacknowledged accesses.
// Address/data widths come from the connected core_mem_arbiter_if.
module core_mem_arbiter #(
    parameter int TIMEOUT = 255   // 1..65535 busy cycles without mem_ack
) (
    input  logic               clk,
    input  logic               reset,
    core_mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
    typedef enum logic {GRANT_FETCH = 1'b0, GRANT_DATA = 1'b1} grant_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state;
    state_t      state_next;
    grant_t      last_grant;
    logic [15:0] wait_cnt;
    logic        if_elig;
    logic        ls_elig;
    logic        grant_if;
    logic        grant_ls;
    logic        mem_done;
    logic        mem_abort;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration in IDLE, completion/abort detection while an access is outstanding.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        grant_if   = 1'b0;
        grant_ls   = 1'b0;
        mem_done   = 1'b0;
        mem_abort  = 1'b0;
        // A requester whose ack is high this cycle has not yet dropped req; keep it out.
        if_elig    = bus.if_req && !bus.if_ack;
        ls_elig    = bus.ls_req && !bus.ls_ack;

        case (state)
            IDLE: begin
                if (ls_elig && (!if_elig || last_grant == GRANT_FETCH)) begin
                    grant_ls   = 1'b1;
                    state_next = DATA;
                end else if (if_elig) begin
                    grant_if   = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH, DATA: begin
                // A real acknowledge beats the watchdog when both land together.
                if (bus.mem_ack) begin
                    mem_done   = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    mem_abort  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered memory request, watchdog counter and completion pulses to the owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant    <= GRANT_FETCH;
            wait_cnt      <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_wstrb <= '0;
            bus.if_ack    <= 1'b0;
            bus.if_err    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.ls_ack    <= 1'b0;
            bus.ls_err    <= 1'b0;
            bus.ls_rdata  <= '0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.if_err <= 1'b0;
            bus.ls_ack <= 1'b0;
            bus.ls_err <= 1'b0;

            if (grant_ls) begin
                bus.mem_req   <= 1'b1;
                bus.mem_addr  <= bus.ls_addr;
                bus.mem_wdata <= bus.ls_wdata;
                bus.mem_we    <= bus.ls_we;
                bus.mem_wstrb <= bus.ls_wstrb;
                last_grant    <= GRANT_DATA;
                wait_cnt      <= '0;
            end else if (grant_if) begin
                // Fetches never write; the old write data is left in place.
                bus.mem_req   <= 1'b1;
                bus.mem_addr  <= bus.if_addr;
                bus.mem_we    <= 1'b0;
                bus.mem_wstrb <= '0;
                last_grant    <= GRANT_FETCH;
                wait_cnt      <= '0;
            end

            if (mem_done || mem_abort) begin
                bus.mem_req <= 1'b0;
                if (state == FETCH) begin
                    bus.if_ack   <= 1'b1;
                    bus.if_err   <= mem_abort;
                    bus.if_rdata <= mem_done ? bus.mem_rdata : '0;
                end else begin
                    bus.ls_ack   <= 1'b1;
                    bus.ls_err   <= mem_abort;
                    bus.ls_rdata <= mem_done ? bus.mem_rdata : '0;
                end
            end else if (state != IDLE) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed scenarios followed by
// randomized traffic, checked by a cycle-level reference model and a
// per-requester response scoreboard.
module tb_core_mem_arbiter;

    localparam int TIMEOUT = 4;
    localparam int NEVER   = 99;   // memory latency value meaning "never acknowledge"

    typedef enum bit {OWN_FETCH, OWN_DATA} owner_t;
    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    logic clk = 1'b0;
    logic reset;

    core_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    core_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected completions, pushed when an access is issued to memory.
    resp_t if_q[$];
    resp_t ls_q[$];

    // Memory behaviour knobs: latency in cycles after mem_req rises (-1 = random).
    int          mem_lat      = -1;
    bit          mem_fix      = 1'b0;
    logic [31:0] mem_fix_data = '0;
    bit          chk_en       = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: access-level view of the arbiter. Each cycle it
    // predicts the outputs of the next cycle and plays the memory.
    // ------------------------------------------------------------------
    int          cyc       = 0;
    bit          m_busy    = 1'b0;
    owner_t      m_owner   = OWN_FETCH;
    owner_t      m_last    = OWN_FETCH;
    int          m_ack_cyc = -1;
    int          m_end     = 0;
    bit          m_abort   = 1'b0;
    logic [31:0] m_data    = '0;

    logic        e_mem_req  = 1'b0;
    logic [31:0] e_addr     = '0;
    logic [31:0] e_wdata    = '0;
    logic        e_we       = 1'b0;
    logic [3:0]  e_wstrb    = '0;
    logic        e_if_ack   = 1'b0;
    logic        e_if_err   = 1'b0;
    logic [31:0] e_if_rdata = '0;
    logic        e_ls_ack   = 1'b0;
    logic        e_ls_err   = 1'b0;
    logic [31:0] e_ls_rdata = '0;

    always @(negedge clk) begin : model_p
        logic  cur_if_ack;
        logic  cur_ls_ack;
        logic  if_el;
        logic  ls_el;
        int    lat;
        resp_t r;

        if (chk_en) begin
            check("mem_req",   32'(bus.mem_req),   32'(e_mem_req));
            check("mem_addr",  bus.mem_addr,       e_addr);
            check("mem_wdata", bus.mem_wdata,      e_wdata);
            check("mem_we",    32'(bus.mem_we),    32'(e_we));
            check("mem_wstrb", 32'(bus.mem_wstrb), 32'(e_wstrb));
            check("if_ack",    32'(bus.if_ack),    32'(e_if_ack));
            check("if_err",    32'(bus.if_err),    32'(e_if_err));
            check("if_rdata",  bus.if_rdata,       e_if_rdata);
            check("ls_ack",    32'(bus.ls_ack),    32'(e_ls_ack));
            check("ls_err",    32'(bus.ls_err),    32'(e_ls_err));
            check("ls_rdata",  bus.ls_rdata,       e_ls_rdata);
        end

        // Memory side for this cycle; stray acks while idle must be ignored.
        if (m_busy && cyc == m_ack_cyc) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = m_data;
        end else if (!m_busy && $urandom_range(0, 3) == 0) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = $urandom;
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
        end

        // Predict next cycle.
        cur_if_ack = e_if_ack;
        cur_ls_ack = e_ls_ack;
        e_if_ack   = 1'b0;
        e_ls_ack   = 1'b0;
        e_if_err   = 1'b0;
        e_ls_err   = 1'b0;

        if (reset) begin
            // An access cut short by reset is never completed.
            if (m_busy) begin
                if (m_owner == OWN_FETCH) r = if_q.pop_back();
                else                      r = ls_q.pop_back();
            end
            m_busy     = 1'b0;
            m_last     = OWN_FETCH;
            e_mem_req  = 1'b0;
            e_addr     = '0;
            e_wdata    = '0;
            e_we       = 1'b0;
            e_wstrb    = '0;
            e_if_rdata = '0;
            e_ls_rdata = '0;
        end else if (m_busy) begin
            if (cyc == m_end) begin
                m_busy    = 1'b0;
                e_mem_req = 1'b0;
                if (m_owner == OWN_FETCH) begin
                    e_if_ack   = 1'b1;
                    e_if_err   = m_abort;
                    e_if_rdata = m_abort ? 32'd0 : m_data;
                end else begin
                    e_ls_ack   = 1'b1;
                    e_ls_err   = m_abort;
                    e_ls_rdata = m_abort ? 32'd0 : m_data;
                end
            end
        end else begin
            if_el = bus.if_req && !cur_if_ack;
            ls_el = bus.ls_req && !cur_ls_ack;
            if (if_el || ls_el) begin
                if (if_el && ls_el) m_owner = (m_last == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
                else                m_owner = ls_el ? OWN_DATA : OWN_FETCH;
                m_last    = m_owner;
                m_busy    = 1'b1;
                lat       = (mem_lat < 0) ? int'($urandom_range(0, TIMEOUT + 2)) : mem_lat;
                m_abort   = (lat > TIMEOUT);
                m_ack_cyc = m_abort ? -1 : cyc + 1 + lat;
                m_end     = m_abort ? cyc + 1 + TIMEOUT : cyc + 1 + lat;
                m_data    = mem_fix ? mem_fix_data : $urandom;
                r.err     = m_abort;
                r.rdata   = m_abort ? 32'd0 : m_data;
                e_mem_req = 1'b1;
                if (m_owner == OWN_DATA) begin
                    e_addr  = bus.ls_addr;
                    e_wdata = bus.ls_wdata;
                    e_we    = bus.ls_we;
                    e_wstrb = bus.ls_wstrb;
                    ls_q.push_back(r);
                end else begin
                    e_addr  = bus.if_addr;
                    e_we    = 1'b0;
                    e_wstrb = '0;
                    if_q.push_back(r);
                end
            end else begin
                e_mem_req = 1'b0;
            end
        end
        cyc++;
    end

    // Scoreboard monitor: pops an expected response whenever a requester is acked.
    always @(negedge clk) begin : scoreboard_p
        resp_t r;
        if (chk_en && bus.if_ack === 1'b1) begin
            if (if_q.size() == 0) begin
                check("if_ack_outstanding", 32'(if_q.size()), 32'd1);
            end else begin
                r = if_q.pop_front();
                check("sb_if_err",   32'(bus.if_err), 32'(r.err));
                check("sb_if_rdata", bus.if_rdata,    r.rdata);
            end
        end
        if (chk_en && bus.ls_ack === 1'b1) begin
            if (ls_q.size() == 0) begin
                check("ls_ack_outstanding", 32'(ls_q.size()), 32'd1);
            end else begin
                r = ls_q.pop_front();
                check("sb_ls_err",   32'(bus.ls_err), 32'(r.err));
                check("sb_ls_rdata", bus.ls_rdata,    r.rdata);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called at posedge + 1)
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ls_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic we, input logic [3:0] wstrb, input bit drop);
        int n;
        bus.ls_req   = 1'b1;
        bus.ls_addr  = addr;
        bus.ls_wdata = wdata;
        bus.ls_we    = we;
        bus.ls_wstrb = wstrb;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.ls_ack !== 1'b1 && n < 200);
        check("ls_ack_wait", 32'(bus.ls_ack), 32'd1);
        if (drop) bus.ls_req = 1'b0;
    endtask

    task automatic if_txn(input logic [31:0] addr, input bit drop);
        int n;
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.if_ack !== 1'b1 && n < 200);
        check("if_ack_wait", 32'(bus.if_ack), 32'd1);
        if (drop) bus.if_req = 1'b0;
    endtask

    initial begin : main_p
        int n;
        reset         = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.ls_req    = 1'b0;
        bus.ls_addr   = '0;
        bus.ls_wdata  = '0;
        bus.ls_we     = 1'b0;
        bus.ls_wstrb  = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        idle(3);
        chk_en = 1'b1;
        reset  = 1'b0;

        // Single load, memory acks two cycles after mem_req rises.
        mem_lat = 2; mem_fix = 1'b1; mem_fix_data = 32'hDEADBEEF;
        ls_txn(32'h100, 32'h0, 1'b0, 4'b0000, 1'b1);
        idle(2);

        // Partial store.
        mem_lat = 3; mem_fix_data = 32'h55AA0F0F;
        ls_txn(32'h104, 32'h1234, 1'b1, 4'b0011, 1'b1);
        idle(2);

        // Both requesters held, memory acks in the first cycle; start from reset so data wins.
        reset = 1'b1; idle(1); reset = 1'b0;
        mem_lat = 0; mem_fix = 1'b0;
        fork
            for (int i = 0; i < 4; i++) ls_txn(32'h2000 + 32'(i * 4), $urandom, 1'b0, 4'b0000, i == 3);
            for (int j = 0; j < 4; j++) if_txn(32'h4000 + 32'(j * 4), j == 3);
        join
        idle(2);

        // Fetch against a silent memory: watchdog abort.
        mem_lat = NEVER;
        if_txn(32'h8000, 1'b1);
        idle(1);

        // Acknowledge in the same cycle the watchdog fires.
        mem_lat = TIMEOUT; mem_fix = 1'b1; mem_fix_data = 32'hCAFEF00D;
        ls_txn(32'h300, 32'h0, 1'b0, 4'b0000, 1'b1);
        mem_fix = 1'b0;
        idle(1);

        // Reset two cycles into a data access; the held request is granted again afterwards.
        mem_lat      = NEVER;
        bus.ls_req   = 1'b1;
        bus.ls_addr  = 32'h400;
        bus.ls_we    = 1'b0;
        bus.ls_wstrb = 4'b0000;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.mem_req !== 1'b1 && n < 20);
        check("mem_req_rise", 32'(bus.mem_req), 32'd1);
        idle(1);
        mem_lat = 1;
        reset   = 1'b1;
        idle(1);
        reset   = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.ls_ack !== 1'b1 && n < 50);
        check("ls_ack_after_reset", 32'(bus.ls_ack), 32'd1);
        bus.ls_req = 1'b0;
        idle(2);

        // Randomized traffic from both requesters.
        mem_lat = -1;
        fork
            for (int i = 0; i < 40; i++) begin
                bit d;
                d = ($urandom_range(0, 1) == 1) || (i == 39);
                ls_txn(32'h1000_0000 | ($urandom & 32'h00FF_FFFC), $urandom,
                       1'($urandom_range(0, 1)), 4'($urandom), d);
                if (d) idle($urandom_range(0, 3));
            end
            for (int j = 0; j < 40; j++) begin
                bit d;
                d = ($urandom_range(0, 1) == 1) || (j == 39);
                if_txn(32'h2000_0000 | ($urandom & 32'h00FF_FFFC), d);
                if (d) idle($urandom_range(0, 3));
            end
        join
        idle(10);

        check("if_q_drained", 32'(if_q.size()), 32'd0);
        check("ls_q_drained", 32'(ls_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog_p
        #400000;
        failures++;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
